// File: rtl/ff_pkg.sv
// Shared types and next-state function for the ff_bank flip-flop channels.
// Used by both the RTL cells and any reference model.
package ff_pkg;

    typedef enum logic [1:0] {
        FF_JK = 2'b00,
        FF_D  = 2'b01,
        FF_T  = 2'b10,
        FF_SR = 2'b11
    } ff_mode_e;

    // SR 11 is illegal and holds the current state.
    function automatic logic next_state(ff_mode_e mode, logic q, logic j, logic k);
        logic nxt;
        nxt = q;
        case (mode)
            FF_JK: begin
                case ({j, k})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    2'b11:   nxt = ~q;
                    default: nxt = q;
                endcase
            end
            FF_D: nxt = j;
            FF_T: nxt = q ^ j;
            FF_SR: begin
                case ({j, k})
                    2'b01:   nxt = 1'b0;
                    2'b10:   nxt = 1'b1;
                    default: nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/ff_cell.sv
// One flip-flop channel: priority rst > load > enabled mode update > hold.
// Also flags an illegal SR input that would be acted on this edge.
module ff_cell
    import ff_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  ff_mode_e mode,
    input  logic     j,
    input  logic     k,
    input  logic     load,
    input  logic     din,
    input  logic     rst_val,
    output logic     q,
    output logic     illegal
);

    logic r_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= rst_val;
        end else if (load) begin
            r_q <= din;
        end else if (en) begin
            r_q <= next_state(mode, r_q, j, k);
        end
    end

    assign q       = r_q;
    assign illegal = en & ~load & (mode == FF_SR) & j & k;

endmodule

// File: rtl/ff_bank.sv
// Bank of WIDTH run-time-selectable JK/D/T/SR flip-flops with enable, load and qn.
// Define FF_BANK_ERR_EN to build the sticky illegal-SR err flag; otherwise err is 0.
module ff_bank
    import ff_pkg::*;
#(
    parameter int                 WIDTH     = 8,
    parameter logic [WIDTH-1:0]   RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic             err,
    input  logic             err_clr
);

    ff_mode_e         w_mode;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_illegal;

    assign w_mode = ff_mode_e'(mode);

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        ff_cell u_cell (
            .clk     (clk),
            .rst     (rst),
            .en      (en),
            .mode    (w_mode),
            .j       (j[i]),
            .k       (k[i]),
            .load    (load),
            .din     (din[i]),
            .rst_val (RESET_VAL[i]),
            .q       (w_q[i]),
            .illegal (w_illegal[i])
        );
    end

    assign q  = w_q;
    assign qn = ~w_q;

`ifdef FF_BANK_ERR_EN
    logic r_err;

    // A new illegal input outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (|w_illegal) begin
            r_err <= 1'b1;
        end else if (err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign err = r_err;
`else
    logic w_unused_err;

    assign w_unused_err = err_clr | (|w_illegal);
    assign err          = 1'b0;
`endif

endmodule
